// File: rtl/jbi_ncio_prqq_rdctl.sv
// Read-side controller for the NCIO PIO request queue register file: issues RF reads
// against the writer pointer and feeds a 2-entry output buffer with a valid/ack handshake.

module jbi_ncio_prqq_rdctl_chk #(
    parameter int AW = 4
) (
    input logic          clk,
    input logic          rst,
    input logic [1:0]    cnt,
    input logic          inflight,
    input logic          pop,
    input logic [2:0]    occ,
    input logic [AW:0]   avail
);

    a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt <= 2'd2);
    a_occ_limit: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, cnt} + {2'b00, inflight}) <= 3'd2);
    a_occ_next:  assert property (@(posedge clk) disable iff (rst) occ <= 3'd2);
    a_avail:     assert property (@(posedge clk) disable iff (rst)
        avail <= {1'b1, {AW{1'b0}}});
    a_capture:   assert property (@(posedge clk) disable iff (rst)
        !(inflight && (cnt == 2'd2) && !pop));

endmodule

module jbi_ncio_prqq_rdctl #(
    parameter int AW = 4,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW:0]   prqq_wptr,
    output logic [AW:0]   prqq_rptr,
    output logic          prqq_empty,
    output logic          prqq_csn_rd,
    output logic [AW-1:0] prqq_raddr,
    input  logic [DW-1:0] prqq_rdata,
    output logic          req_vld,
    output logic [DW-1:0] req_data,
    input  logic          req_ack
);

    logic [AW:0]   rptr_r;
    logic          inflight_r;
    logic [1:0]    cnt_r;
    logic          vld_r;
    logic [DW-1:0] obuf0_r;
    logic [DW-1:0] obuf1_r;

    logic [AW:0]   avail_s;
    logic          empty_s;
    logic          pop_s;
    logic [2:0]    occ_s;
    logic          issue_s;
    logic [1:0]    cap_idx_s;
    logic [DW-1:0] obuf0_nxt_s;
    logic [DW-1:0] obuf1_nxt_s;

    // Occupancy after this cycle counts buffered entries plus the read already in the RF pipe.
    assign avail_s   = prqq_wptr - rptr_r;
    assign empty_s   = (avail_s == {(AW+1){1'b0}});
    assign pop_s     = vld_r & req_ack;
    assign occ_s     = {1'b0, cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign issue_s   = ~rst & ~empty_s & (occ_s < 3'd2);
    assign cap_idx_s = cnt_r - {1'b0, pop_s};

    // Next output-buffer contents: shift on pop, then land captured RF data behind survivors.
    always_comb begin
        obuf0_nxt_s = obuf0_r;
        obuf1_nxt_s = obuf1_r;
        if (pop_s) begin
            obuf0_nxt_s = obuf1_r;
        end else begin
            obuf0_nxt_s = obuf0_r;
        end
        if (inflight_r) begin
            case (cap_idx_s)
                2'd0:    obuf0_nxt_s = prqq_rdata;
                2'd1:    obuf1_nxt_s = prqq_rdata;
                default: obuf1_nxt_s = obuf1_r;
            endcase
        end else begin
            obuf1_nxt_s = obuf1_nxt_s;
        end
    end

    // Pointer, in-flight flag, buffer count and buffer storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_r     <= {(AW+1){1'b0}};
            inflight_r <= 1'b0;
            cnt_r      <= 2'd0;
            vld_r      <= 1'b0;
            obuf0_r    <= {DW{1'b0}};
            obuf1_r    <= {DW{1'b0}};
        end else begin
            rptr_r     <= issue_s ? (rptr_r + {{AW{1'b0}}, 1'b1}) : rptr_r;
            inflight_r <= issue_s;
            cnt_r      <= occ_s[1:0];
            vld_r      <= (occ_s[1:0] != 2'd0);
            obuf0_r    <= obuf0_nxt_s;
            obuf1_r    <= obuf1_nxt_s;
        end
    end

    assign prqq_rptr   = rptr_r;
    assign prqq_empty  = empty_s;
    assign prqq_csn_rd = ~issue_s;
    assign prqq_raddr  = rptr_r[AW-1:0];
    assign req_vld     = vld_r;
    assign req_data    = obuf0_r;

    jbi_ncio_prqq_rdctl_chk #(.AW(AW)) u_chk (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt_r),
        .inflight (inflight_r),
        .pop      (pop_s),
        .occ      (occ_s),
        .avail    (avail_s)
    );

endmodule

// File: tb/tb_jbi_ncio_prqq_rdctl.sv
// Randomized bench for the PRQQ read controller: queue-based reference model plus directed
// literal checks for reset, latency, streaming, backpressure, wrap and mid-stream reset.

module tb_jbi_ncio_prqq_rdctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_ack = 1'b0;
    logic [4:0]  prqq_wptr = 5'd5;
    logic [4:0]  prqq_rptr;
    logic        prqq_empty;
    logic        prqq_csn_rd;
    logic [3:0]  prqq_raddr;
    logic [63:0] prqq_rdata;
    logic        req_vld;
    logic [63:0] req_data;

    logic [63:0] mem [16];
    logic [4:0]  rst_wptr = 5'd5;

    int checks = 0;
    int errors = 0;

    // reference model: read pointer, one RF read in flight, output queue, write-order queue
    int          rptr_m = 0;
    bit          infl_m = 1'b0;
    logic [63:0] infl_d = 64'd0;
    logic [63:0] obq[$];
    logic [63:0] wq[$];
    bit          issue_m;
    bit          pop_m;

    jbi_ncio_prqq_rdctl #(.AW(4), .DW(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .prqq_wptr   (prqq_wptr),
        .prqq_rptr   (prqq_rptr),
        .prqq_empty  (prqq_empty),
        .prqq_csn_rd (prqq_csn_rd),
        .prqq_raddr  (prqq_raddr),
        .prqq_rdata  (prqq_rdata),
        .req_vld     (req_vld),
        .req_data    (req_data),
        .req_ack     (req_ack)
    );

    always #5 clk = ~clk;

    // register file read port: one-cycle read latency
    always @(posedge clk) begin
        if (!prqq_csn_rd) prqq_rdata <= mem[prqq_raddr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        int  avail;
        int  occ;
        bit  vld_e;
        vld_e   = (obq.size() != 0);
        avail   = (int'(prqq_wptr) - rptr_m + 32) % 32;
        pop_m   = !rst && vld_e && req_ack;
        occ     = obq.size() + int'(infl_m) - int'(pop_m);
        issue_m = !rst && (avail != 0) && (occ < 2);
        chk("rptr",    {59'd0, prqq_rptr},  64'(rptr_m));
        chk("empty",   {63'd0, prqq_empty}, {63'd0, (avail == 0)});
        chk("csn_rd",  {63'd0, prqq_csn_rd}, {63'd0, !issue_m});
        chk("raddr",   {60'd0, prqq_raddr}, 64'(rptr_m % 16));
        chk("req_vld", {63'd0, req_vld},    {63'd0, vld_e});
        if (vld_e) chk("req_data", req_data, obq[0]);
        if (pop_m) begin
            if (wq.size() == 0) begin
                chk("order_underflow", 64'd1, 64'd0);
            end else begin
                chk("order", req_data, wq.pop_front());
            end
        end
    endtask

    task automatic step();
        if (rst) begin
            rptr_m = 0;
            infl_m = 1'b0;
            obq.delete();
            wq.delete();
        end else begin
            if (pop_m) void'(obq.pop_front());
            if (infl_m) obq.push_back(infl_d);
            if (issue_m) begin
                infl_d = mem[rptr_m % 16];
                rptr_m = (rptr_m + 1) % 32;
            end
            infl_m = issue_m;
        end
    endtask

    // one clock: drive at the falling edge, check just after, then advance the model
    task automatic cyc(input bit r, input bit ack, input bit wr, input logic [63:0] d);
        logic [4:0] occw;
        @(negedge clk);
        rst = r;
        req_ack = ack;
        if (r) begin
            prqq_wptr = rst_wptr;
        end else if (wr) begin
            occw = prqq_wptr - prqq_rptr;
            if (occw < 5'd16) begin
                mem[prqq_wptr[3:0]] = d;
                prqq_wptr = prqq_wptr + 5'd1;
                wq.push_back(d);
            end
        end
        #1;
        compare();
        step();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [63:0] d0;
        logic [63:0] first;
        int          vld_cnt;
        int          rises;
        bit          prev_vld;
        int          ra[$];
        int          exp_ra[4];
        exp_ra = '{14, 15, 0, 1};
        for (int i = 0; i < 16; i++) mem[i] = 64'd0;

        // reset with a non-zero writer pointer: reader must stay idle
        cyc(1'b1, 1'b0, 1'b0, 64'd0);
        cyc(1'b1, 1'b0, 1'b0, 64'd0);
        chk("rst_rptr",  {59'd0, prqq_rptr},  64'd0);
        chk("rst_csn",   {63'd0, prqq_csn_rd}, 64'd1);
        chk("rst_vld",   {63'd0, req_vld},    64'd0);
        chk("rst_data",  req_data,            64'd0);
        rst_wptr = 5'd0;
        cyc(1'b1, 1'b0, 1'b0, 64'd0);

        // single entry latency
        d0 = 64'hDEAD_BEEF_0123_4567;
        cyc(1'b0, 1'b1, 1'b1, d0);
        chk("lat_csn",   {63'd0, prqq_csn_rd}, 64'd0);
        chk("lat_raddr", {60'd0, prqq_raddr},  64'd0);
        cyc(1'b0, 1'b1, 1'b0, 64'd0);
        chk("lat_vld_early", {63'd0, req_vld}, 64'd0);
        cyc(1'b0, 1'b1, 1'b0, 64'd0);
        chk("lat_vld",   {63'd0, req_vld}, 64'd1);
        chk("lat_data",  req_data, d0);

        // streaming: 16 entries with ack held high, no bubbles
        vld_cnt = 0; rises = 0; prev_vld = 1'b0;
        for (int i = 0; i < 22; i++) begin
            cyc(1'b0, 1'b1, (i < 16), rnd64());
            if (req_vld) vld_cnt++;
            if (req_vld && !prev_vld) rises++;
            prev_vld = req_vld;
        end
        chk("stream_count", 64'(vld_cnt), 64'd16);
        chk("stream_runs",  64'(rises),   64'd1);

        // backpressure from a clean reset
        cyc(1'b1, 1'b0, 1'b0, 64'd0);
        first = rnd64();
        cyc(1'b0, 1'b0, 1'b1, first);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, rnd64());
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 64'd0);
        chk("bp_rptr", {59'd0, prqq_rptr},  64'd2);
        chk("bp_csn",  {63'd0, prqq_csn_rd}, 64'd1);
        chk("bp_vld",  {63'd0, req_vld},    64'd1);
        chk("bp_data", req_data, first);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 64'd0);
        chk("bp_final_rptr", {59'd0, prqq_rptr}, 64'd5);
        chk("bp_empty",      {63'd0, prqq_empty}, 64'd1);
        chk("bp_drained",    {63'd0, req_vld},    64'd0);

        // advance to 5'h1E, then wrap
        for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, (i < 25), rnd64());
        chk("pre_wrap_rptr", {59'd0, prqq_rptr}, 64'h1E);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, (i < 4), rnd64());
            if (!prqq_csn_rd) ra.push_back(int'(prqq_raddr));
        end
        chk("wrap_reads", 64'(ra.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ra.size()) chk("wrap_raddr", 64'(ra[i]), 64'(exp_ra[i]));
        end
        chk("wrap_rptr", {59'd0, prqq_rptr}, 64'h02);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            cyc(1'b0, (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 9) < 6), rnd64());
        end
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b0, 64'd0);
        chk("rand_drained", {63'd0, prqq_empty}, 64'd1);

        // reset with one entry buffered and one read in flight
        cyc(1'b0, 1'b0, 1'b1, rnd64());
        cyc(1'b0, 1'b0, 1'b1, rnd64());
        cyc(1'b0, 1'b0, 1'b0, 64'd0);
        chk("mid_vld_before", {63'd0, req_vld}, 64'd1);
        cyc(1'b1, 1'b0, 1'b0, 64'd0);
        cyc(1'b0, 1'b0, 1'b0, 64'd0);
        chk("mid_vld",  {63'd0, req_vld},     64'd0);
        chk("mid_rptr", {59'd0, prqq_rptr},   64'd0);
        chk("mid_csn",  {63'd0, prqq_csn_rd}, 64'd1);
        for (int i = 0; i < 60; i++) cyc(1'b0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), rnd64());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
